// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared UART constants, rx state enum and baud divider helper
package uart_rx_fifo_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    // Clocks per oversample tick; never below one so the tick counter stays legal.
    function automatic int calc_div(input int sys_clk_freq, input int baud_rate);
        int d;
        d = sys_clk_freq / (baud_rate * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// rtl/uart_rx_fifo_sync_fifo.sv - first-word-fall-through FIFO with stream handshakes
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push;
    logic             pop;

    assign m_tvalid = (count_q != '0);
    assign full     = (count_q == FULL_CNT);
    assign pop      = m_tready & m_tvalid;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign s_tready = ~full | pop;
    assign push     = s_tvalid & s_tready;
    assign m_tdata  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= s_tdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 oversampling UART receiver feeding a small receive FIFO
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       overrun,
    output logic       frame_err
);
    localparam int DIV = calc_div(SYS_CLK_FREQ, BAUD_RATE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [3:0]    MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    logic            rx_meta_q;
    logic            rx_s_q;
    logic [TW-1:0]   tick_cnt_q;
    logic            tick;
    logic            tick_clr;
    rx_state_e       state_q, state_d;
    logic [3:0]      tcnt_q, tcnt_d;
    logic [2:0]      bidx_q, bidx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            need_high_q, need_high_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q;
    logic            push;
    logic            fifo_ready;
    logic            fifo_valid;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            tick_cnt_q  <= '0;
            state_q     <= IDLE;
            tcnt_q      <= '0;
            bidx_q      <= '0;
            shreg_q     <= '0;
            need_high_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            tick_cnt_q  <= (tick_clr || tick) ? '0 : tick_cnt_q + 1'b1;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bidx_q      <= bidx_d;
            shreg_q     <= shreg_d;
            need_high_q <= need_high_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= push & ~fifo_ready;
        end
    end

    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bidx_d      = bidx_q;
        shreg_d     = shreg_q;
        need_high_d = need_high_q;
        frame_err_d = 1'b0;
        tick_clr    = 1'b0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                // After a low stop bit the line must recover before a new start is trusted.
                if (need_high_q) begin
                    if (rx_s_q) begin
                        need_high_d = 1'b0;
                    end
                end else if (!rx_s_q) begin
                    state_d  = START;
                    tcnt_d   = '0;
                    tick_clr = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (tcnt_q == MID_TICK) begin
                        tcnt_d  = '0;
                        bidx_d  = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == LAST_TICK) begin
                        shreg_d[bidx_q] = rx_s_q;
                        bidx_d          = bidx_q + 1'b1;
                        if (bidx_q == LAST_BIT) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == LAST_TICK) begin
                        push        = rx_s_q;
                        frame_err_d = ~rx_s_q;
                        need_high_d = ~rx_s_q;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (shreg_q),
        .s_tvalid (push),
        .s_tready (fifo_ready),
        .m_tdata  (rd_data),
        .m_tvalid (fifo_valid),
        .m_tready (rd_en),
        .full     (full)
    );

    assign empty     = ~fifo_valid;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed and random frames checked against a byte-queue model
module tb_uart_rx_fifo;
    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int DEPTH  = 8;
    localparam int BIT    = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, overrun, frame_err;

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int exp_ferr = 0;
    int exp_ovr = 0;
    logic [7:0] model_q[$];

    uart_rx_fifo #(
        .SYS_CLK_FREQ (CLK_HZ),
        .BAUD_RATE    (BAUD),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 frame; the stop sample lands on the 155th edge after the start edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic rd_at_stop);
        int   pre;
        logic popped, accept, e_pre, e_post;
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(posedge clk);
            #1 rx = b[i];
        end
        repeat (BIT) @(posedge clk);
        #1 rx = stop_bit;
        repeat (10) @(posedge clk);
        #1;
        pre    = model_q.size();
        popped = rd_at_stop && (pre > 0);
        accept = stop_bit && ((pre < DEPTH) || popped);
        e_pre  = empty;
        if (popped) chk("head_at_stop", {24'd0, rd_data}, {24'd0, model_q[0]});
        rd_en = rd_at_stop;
        @(posedge clk);
        #1 rd_en = 1'b0;
        e_post = empty;
        chk("frame_err_pulse", {31'd0, frame_err}, {31'd0, ~stop_bit});
        chk("overrun_pulse", {31'd0, overrun}, {31'd0, stop_bit & ~accept});
        if (accept && pre == 0) begin
            chk("empty_before_stop", {31'd0, e_pre}, 32'd1);
            chk("empty_after_stop", {31'd0, e_post}, 32'd0);
        end
        if (popped) void'(model_q.pop_front());
        if (!stop_bit) exp_ferr++;
        else if (!accept) exp_ovr++;
        if (accept) model_q.push_back(b);
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic pop_n(input int n);
        for (int k = 0; k < n && model_q.size() > 0; k++) begin
            chk("not_empty", {31'd0, empty}, 32'd0);
            chk("rd_data", {24'd0, rd_data}, {24'd0, model_q[0]});
            void'(model_q.pop_front());
            rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
        end
    endtask

    task automatic drain();
        pop_n(DEPTH + 1);
        chk("empty_after_drain", {31'd0, empty}, 32'd1);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_empty", {31'd0, empty}, 32'd1);
        chk("reset_full", {31'd0, full}, 32'd0);
        chk("reset_rd_data", {24'd0, rd_data}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);

        // pop while empty must be harmless
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        chk("pop_empty", {31'd0, empty}, 32'd1);

        send_frame(8'h41, 1'b1, 1'b0);
        chk("first_byte", {24'd0, rd_data}, 32'h41);
        drain();

        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drain();
        chk("no_ferr_b2b", ferr_cnt, exp_ferr);

        @(posedge clk); #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("glitch_empty", {31'd0, empty}, 32'd1);
        chk("glitch_no_ferr", ferr_cnt, exp_ferr);
        send_frame(8'h5A, 1'b1, 1'b0);
        drain();

        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("ferr_count", ferr_cnt, exp_ferr);
        chk("ferr_fifo_empty", {31'd0, empty}, 32'd1);

        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b0);
        chk("full_after_8", {31'd0, full}, 32'd1);
        send_frame(8'h09, 1'b1, 1'b0);
        chk("overrun_count", ovr_cnt, exp_ovr);
        drain();

        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b0);
        send_frame(8'h09, 1'b1, 1'b1);
        chk("overrun_with_pop", ovr_cnt, exp_ovr);
        chk("full_after_swap", {31'd0, full}, 32'd1);
        drain();

        // break: line low well past a full frame
        @(posedge clk); #1 rx = 1'b0;
        exp_ferr++;
        repeat (BIT * 12) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("break_one_ferr", ferr_cnt, exp_ferr);
        send_frame(8'hC3, 1'b1, 1'b0);
        drain();

        // reset during bit 4 with a byte already buffered
        send_frame(8'h77, 1'b1, 1'b0);
        @(posedge clk); #1 rx = 1'b0;
        repeat (BIT * 5 + 8) @(posedge clk);
        #1 rst_n = 1'b0;
        rx = 1'b1;
        model_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midreset_empty", {31'd0, empty}, 32'd1);
        chk("midreset_rd_data", {24'd0, rd_data}, 32'd0);
        repeat (20) @(posedge clk);
        send_frame(8'h96, 1'b1, 1'b0);
        drain();

        for (int n = 0; n < 14; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            send_frame(rb, rs, 1'($urandom_range(0, 1)));
            chk("rand_full", {31'd0, full}, {31'd0, model_q.size() == DEPTH});
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
            pop_n($urandom_range(0, 2));
        end
        drain();
        chk("final_ferr_count", ferr_cnt, exp_ferr);
        chk("final_ovr_count", ovr_cnt, exp_ovr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
